// File: rtl/branch_pred_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_pred_ctrl_pkg
//   Shared definitions for the branch prediction controller:
//     - PC_IDX_LSB : bit offset of the predictor table index inside the PC
//                    (instructions are word aligned, so bits [1:0] are skipped)
//     - bp_cnt_e   : 2-bit saturating counter encodings of the predictor table
//     - cnt_predicts_taken() : direction implied by a counter value
//   No ports (package).
// -----------------------------------------------------------------------------
package branch_pred_ctrl_pkg;

    localparam int PC_IDX_LSB = 2;

    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'b00,
        CNT_WEAK_NT   = 2'b01,
        CNT_WEAK_T    = 2'b10,
        CNT_STRONG_T  = 2'b11
    } bp_cnt_e;

    // Upper half of the counter range predicts taken.
    function automatic logic cnt_predicts_taken(input logic [1:0] cnt);
        return (cnt == CNT_WEAK_T) || (cnt == CNT_STRONG_T);
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// -----------------------------------------------------------------------------
// bp_inflight_fifo
//   Synchronous FIFO holding predicted branches that have not yet resolved.
//   Each entry is {table index, predicted direction}. The head entry is
//   readable combinationally so the resolve logic can compare it in the same
//   cycle it is popped.
//
//   Ports:
//     cpu_clk    in   clock, rising edge
//     cpu_rstn   in   asynchronous active-low reset
//     push       in   write push_data at the tail
//     push_data  in   entry to store [width-1:0]
//     pop        in   drop the head entry (ignored when empty)
//     clear      in   discard every entry; wins over push/pop
//     head_data  out  oldest entry [width-1:0]
//     count      out  number of stored entries [$clog2(depth):0]
//     empty      out  count == 0
// -----------------------------------------------------------------------------
module bp_inflight_fifo
    import branch_pred_ctrl_pkg::*;
#(
    parameter int width = 9,
    parameter int depth = 4
) (
    input  logic                    cpu_clk,
    input  logic                    cpu_rstn,
    input  logic                    push,
    input  logic [width-1:0]        push_data,
    input  logic                    pop,
    input  logic                    clear,
    output logic [width-1:0]        head_data,
    output logic [$clog2(depth):0]  count,
    output logic                    empty
);

    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int cnt_w = $clog2(depth) + 1;

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr_reg;
    logic [ptr_w-1:0] rd_ptr_reg;
    logic [cnt_w-1:0] count_reg;

    logic pop_eff;
    logic push_eff;
    logic full;

    assign full      = (count_reg == cnt_w'(depth));
    assign empty     = (count_reg == '0);
    assign pop_eff   = pop && !empty;
    // A full FIFO can still take a push when the head leaves on the same edge.
    assign push_eff  = push && (!full || pop_eff);
    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge cpu_clk) begin
        if (push_eff && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_w'(1);
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_w'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + cnt_w'(1);
                2'b01:   count_reg <= count_reg - cnt_w'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// -----------------------------------------------------------------------------
// branch_pred_ctrl
//   Control path around an external 2-bit-counter predictor table.
//   Fetch: an accepted branch is looked up (one cycle table latency); the
//   prediction is reported and the {index, prediction} pair is queued in
//   bp_inflight_fifo. Execute: each resolve retires the oldest in-flight
//   branch, drives one table update and flags a mispredict. A mispredict or
//   an external flush squashes everything younger.
//
//   Ports:
//     cpu_clk           in   clock, rising edge
//     cpu_rstn          in   asynchronous active-low reset
//     fetch_valid       in   branch at fetch wants a prediction
//     fetch_pc          in   [31:0] PC of that branch
//     fetch_ready       out  fetch accepted when fetch_valid && fetch_ready
//     predictor_raddr   out  [addr_width-1:0] table read index (combinational)
//     predictor_rd_data in   [1:0] counter, valid the cycle after raddr
//     pred_valid        out  prediction pulse
//     pred_taken        out  predicted direction
//     resolve_valid     in   oldest in-flight branch resolved
//     resolve_taken     in   its actual direction
//     flush             in   external pipeline flush
//     predictor_wen     out  table update strobe
//     predictor_waddr   out  [addr_width-1:0] table update index
//     branch_taken_ex   out  actual direction for the table update
//     mispredict        out  pulse with predictor_wen when prediction was wrong
//     resolve_err       out  sticky: resolve arrived with nothing in flight
//     inflight_cnt      out  [$clog2(fifo_depth):0] current occupancy
// -----------------------------------------------------------------------------
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int entry_num  = 256,
    parameter int addr_width = $clog2(entry_num),
    parameter int fifo_depth = 4
) (
    input  logic                         cpu_clk,
    input  logic                         cpu_rstn,
    input  logic                         fetch_valid,
    input  logic [31:0]                  fetch_pc,
    output logic                         fetch_ready,
    output logic [addr_width-1:0]        predictor_raddr,
    input  logic [1:0]                   predictor_rd_data,
    output logic                         pred_valid,
    output logic                         pred_taken,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    input  logic                         flush,
    output logic                         predictor_wen,
    output logic [addr_width-1:0]        predictor_waddr,
    output logic                         branch_taken_ex,
    output logic                         mispredict,
    output logic                         resolve_err,
    output logic [$clog2(fifo_depth):0]  inflight_cnt
);

    localparam int cnt_w   = $clog2(fifo_depth) + 1;
    localparam int entry_w = addr_width + 1;

    // Lookup stage: the fetch accepted on the previous edge, waiting for the
    // table read data.
    logic                  lkp_valid_reg;
    logic                  lkp_valid_next;
    logic [addr_width-1:0] lkp_idx_reg;
    logic [addr_width-1:0] lkp_idx_next;

    logic                  fetch_ready_reg;
    logic                  fetch_ready_next;
    logic [cnt_w-1:0]      inflight_cnt_reg;
    logic                  predictor_wen_reg;
    logic [addr_width-1:0] predictor_waddr_reg;
    logic [addr_width-1:0] predictor_waddr_next;
    logic                  branch_taken_ex_reg;
    logic                  branch_taken_ex_next;
    logic                  mispredict_reg;
    logic                  resolve_err_reg;

    logic [entry_w-1:0]    fifo_head;
    logic [cnt_w-1:0]      fifo_count;
    logic                  fifo_empty;

    logic                  accept;
    logic                  lkp_taken;
    logic                  fifo_pop;
    logic                  bypass;
    logic                  res_hit;
    logic [addr_width-1:0] res_idx;
    logic                  res_pred;
    logic                  mis;
    logic                  discard;
    logic                  fifo_push;
    logic [cnt_w-1:0]      occ_now;
    logic [cnt_w-1:0]      fifo_count_next;
    logic [cnt_w-1:0]      occ_next;
    logic                  unused_pc_bits;

    assign predictor_raddr = fetch_pc[PC_IDX_LSB +: addr_width];
    assign unused_pc_bits  = ^{fetch_pc[31:PC_IDX_LSB+addr_width], fetch_pc[PC_IDX_LSB-1:0]};

    always_comb begin
        accept    = fetch_valid && fetch_ready_reg;
        lkp_taken = cnt_predicts_taken(predictor_rd_data);
        occ_now   = fifo_count + cnt_w'(lkp_valid_reg);

        // Oldest in-flight branch: FIFO head, or the lookup stage directly
        // when it is the only one outstanding.
        fifo_pop  = resolve_valid && !fifo_empty;
        bypass    = resolve_valid && fifo_empty && lkp_valid_reg;
        res_hit   = fifo_pop || bypass;
        res_idx   = fifo_pop ? fifo_head[entry_w-1:1] : lkp_idx_reg;
        res_pred  = fifo_pop ? fifo_head[0] : lkp_taken;
        mis       = res_hit && (res_pred != resolve_taken);

        // Everything younger than a mispredicted or flushed branch is dropped,
        // including a fetch accepted on the same edge.
        discard   = mis || flush;
        fifo_push = lkp_valid_reg && !bypass && !discard;

        lkp_valid_next = accept && !discard;
        lkp_idx_next   = accept ? predictor_raddr : lkp_idx_reg;

        if (discard) begin
            fifo_count_next = '0;
        end else begin
            fifo_count_next = fifo_count + cnt_w'(fifo_push) - cnt_w'(fifo_pop);
        end
        occ_next         = fifo_count_next + cnt_w'(lkp_valid_next);
        fetch_ready_next = (occ_next < cnt_w'(fifo_depth));

        predictor_waddr_next = res_hit ? res_idx : predictor_waddr_reg;
        branch_taken_ex_next = res_hit ? resolve_taken : branch_taken_ex_reg;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            lkp_valid_reg       <= 1'b0;
            lkp_idx_reg         <= '0;
            fetch_ready_reg     <= 1'b1;
            inflight_cnt_reg    <= '0;
            predictor_wen_reg   <= 1'b0;
            predictor_waddr_reg <= '0;
            branch_taken_ex_reg <= 1'b0;
            mispredict_reg      <= 1'b0;
            resolve_err_reg     <= 1'b0;
        end else begin
            lkp_valid_reg       <= lkp_valid_next;
            lkp_idx_reg         <= lkp_idx_next;
            fetch_ready_reg     <= fetch_ready_next;
            inflight_cnt_reg    <= occ_next;
            predictor_wen_reg   <= res_hit;
            predictor_waddr_reg <= predictor_waddr_next;
            branch_taken_ex_reg <= branch_taken_ex_next;
            mispredict_reg      <= mis;
            if (resolve_valid && (occ_now == '0)) begin
                resolve_err_reg <= 1'b1;
            end
        end
    end

    bp_inflight_fifo #(
        .width (entry_w),
        .depth (fifo_depth)
    ) u_inflight_fifo (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .push      (fifo_push),
        .push_data ({lkp_idx_reg, lkp_taken}),
        .pop       (fifo_pop),
        .clear     (discard),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // The table data only arrives in the prediction cycle, so the direction
    // is taken straight from it, qualified by the registered valid.
    assign pred_valid      = lkp_valid_reg;
    assign pred_taken      = lkp_valid_reg && lkp_taken;
    assign fetch_ready     = fetch_ready_reg;
    assign inflight_cnt    = inflight_cnt_reg;
    assign predictor_wen   = predictor_wen_reg;
    assign predictor_waddr = predictor_waddr_reg;
    assign branch_taken_ex = branch_taken_ex_reg;
    assign mispredict      = mispredict_reg;
    assign resolve_err     = resolve_err_reg;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
module tb_branch_pred_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = 32'h0;
    logic        fetch_ready;
    logic [7:0]  predictor_raddr;
    logic [1:0]  predictor_rd_data = 2'b00;
    logic        pred_valid;
    logic        pred_taken;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        flush = 1'b0;
    logic        predictor_wen;
    logic [7:0]  predictor_waddr;
    logic        branch_taken_ex;
    logic        mispredict;
    logic        resolve_err;
    logic [2:0]  inflight_cnt;

    branch_pred_ctrl dut (
        .cpu_clk           (cpu_clk),
        .cpu_rstn          (cpu_rstn),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_ready       (fetch_ready),
        .predictor_raddr   (predictor_raddr),
        .predictor_rd_data (predictor_rd_data),
        .pred_valid        (pred_valid),
        .pred_taken        (pred_taken),
        .resolve_valid     (resolve_valid),
        .resolve_taken     (resolve_taken),
        .flush             (flush),
        .predictor_wen     (predictor_wen),
        .predictor_waddr   (predictor_waddr),
        .branch_taken_ex   (branch_taken_ex),
        .mispredict        (mispredict),
        .resolve_err       (resolve_err),
        .inflight_cnt      (inflight_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Predictor table model: one-cycle registered read.
    logic [1:0] tbl [256];
    always @(posedge cpu_clk) predictor_rd_data <= tbl[predictor_raddr];

    int total = 0;
    int bad = 0;

    // Scoreboard: expected predictions and expected {waddr, taken_ex, mispredict}.
    bit         pred_q[$];
    logic [9:0] upd_q[$];
    bit         mon_pred;
    logic [9:0] mon_upd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // Output monitor: every pred_valid / predictor_wen pulse must match the
    // oldest expected entry.
    always @(negedge cpu_clk) begin
        if (pred_valid) begin
            if (pred_q.size() == 0) begin
                chk("pred_unexpected", {31'd0, pred_valid}, 32'd0);
            end else begin
                mon_pred = pred_q.pop_front();
                chk("pred_taken", {31'd0, pred_taken}, {31'd0, mon_pred});
                $display("pred   taken=%0d exp=%0d", pred_taken, mon_pred);
            end
        end
        if (predictor_wen) begin
            if (upd_q.size() == 0) begin
                chk("upd_unexpected", {31'd0, predictor_wen}, 32'd0);
            end else begin
                mon_upd = upd_q.pop_front();
                chk("upd_waddr", {24'd0, predictor_waddr}, {24'd0, mon_upd[9:2]});
                chk("upd_taken", {31'd0, branch_taken_ex}, {31'd0, mon_upd[1]});
                chk("upd_mispredict", {31'd0, mispredict}, {31'd0, mon_upd[0]});
                $display("update waddr=%02h taken=%0d mis=%0d exp=%03h",
                         predictor_waddr, branch_taken_ex, mispredict, mon_upd);
            end
        end else if (mispredict) begin
            chk("mis_without_wen", {31'd0, mispredict}, 32'd0);
        end
    end

    initial begin
        bit exp3 [3];
        for (int i = 0; i < 256; i++) tbl[i] = 2'b00;

        // Reset state
        repeat (3) @(posedge cpu_clk);
        #1;
        chk("rst_wen", {31'd0, predictor_wen}, 32'd0);
        chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_mis", {31'd0, mispredict}, 32'd0);
        chk("rst_err", {31'd0, resolve_err}, 32'd0);
        chk("rst_cnt", {29'd0, inflight_cnt}, 32'd0);
        chk("rst_waddr", {24'd0, predictor_waddr}, 32'd0);
        cpu_rstn = 1'b1;
        chk("ready_after_rst", {31'd0, fetch_ready}, 32'd1);

        // Single fetch, weak-NT, resolved taken -> mispredict
        tbl[8'hF5] = 2'b01;
        fetch_valid = 1'b1;
        fetch_pc = 32'h3D4;
        #1;
        chk("raddr_3d4", {24'd0, predictor_raddr}, 32'hF5);
        pred_q.push_back(1'b0);
        tick();
        fetch_valid = 1'b0;
        tick();
        chk("cnt_one", {29'd0, inflight_cnt}, 32'd1);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        upd_q.push_back({8'hF5, 1'b1, 1'b1});
        tick();
        resolve_valid = 1'b0;
        chk("cnt_after_mis", {29'd0, inflight_cnt}, 32'd0);
        tick();
        tick();

        // Fill to capacity with strong-T, then resolve all taken
        for (int i = 0; i < 4; i++) tbl[8'h40 + i] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1;
            fetch_pc = 32'h100 + 32'(4 * i);
            chk("ready_fill", {31'd0, fetch_ready}, 32'd1);
            pred_q.push_back(1'b1);
            tick();
        end
        fetch_pc = 32'h200;
        chk("ready_full", {31'd0, fetch_ready}, 32'd0);
        chk("cnt_full", {29'd0, inflight_cnt}, 32'd4);
        tick();
        fetch_valid = 1'b0;
        chk("ready_full_hold", {31'd0, fetch_ready}, 32'd0);
        chk("cnt_full_hold", {29'd0, inflight_cnt}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            resolve_valid = 1'b1;
            resolve_taken = 1'b1;
            upd_q.push_back({8'(8'h40 + i), 1'b1, 1'b0});
            tick();
        end
        resolve_valid = 1'b0;
        chk("cnt_drained", {29'd0, inflight_cnt}, 32'd0);
        chk("ready_drained", {31'd0, fetch_ready}, 32'd1);
        tick();
        tick();

        // Three in flight, oldest mispredicts while a fourth is accepted
        tbl[8'hC0] = 2'b00;
        tbl[8'hC1] = 2'b11;
        tbl[8'hC2] = 2'b10;
        tbl[8'hC3] = 2'b11;
        exp3[0] = 1'b0;
        exp3[1] = 1'b1;
        exp3[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1;
            fetch_pc = 32'h300 + 32'(4 * i);
            pred_q.push_back(exp3[i]);
            tick();
        end
        fetch_pc = 32'h30C;
        chk("ready_three", {31'd0, fetch_ready}, 32'd1);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        upd_q.push_back({8'hC0, 1'b1, 1'b1});
        tick();
        fetch_valid = 1'b0;
        resolve_valid = 1'b0;
        chk("cnt_squash", {29'd0, inflight_cnt}, 32'd0);
        chk("pred_suppressed", {31'd0, pred_valid}, 32'd0);
        chk("ready_squash", {31'd0, fetch_ready}, 32'd1);
        tick();
        tick();

        // Bypass: resolve while the only branch is still in the lookup stage
        fetch_valid = 1'b1;
        fetch_pc = 32'h500;
        pred_q.push_back(1'b1);
        tick();
        fetch_valid = 1'b0;
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        upd_q.push_back({8'h40, 1'b0, 1'b1});
        tick();
        resolve_valid = 1'b0;
        chk("cnt_bypass", {29'd0, inflight_cnt}, 32'd0);
        tick();
        tick();

        // Resolve with nothing in flight
        chk("err_before", {31'd0, resolve_err}, 32'd0);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        tick();
        resolve_valid = 1'b0;
        chk("err_set", {31'd0, resolve_err}, 32'd1);
        chk("err_no_wen", {31'd0, predictor_wen}, 32'd0);
        repeat (3) tick();
        chk("err_sticky", {31'd0, resolve_err}, 32'd1);

        // Flush and resolve on the same edge with two in flight
        tbl[8'h00] = 2'b10;
        tbl[8'h01] = 2'b10;
        fetch_valid = 1'b1;
        fetch_pc = 32'h400;
        pred_q.push_back(1'b1);
        tick();
        fetch_pc = 32'h404;
        pred_q.push_back(1'b1);
        tick();
        fetch_valid = 1'b0;
        tick();
        chk("cnt_two", {29'd0, inflight_cnt}, 32'd2);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        flush = 1'b1;
        upd_q.push_back({8'h00, 1'b1, 1'b0});
        tick();
        resolve_valid = 1'b0;
        flush = 1'b0;
        chk("cnt_flush", {29'd0, inflight_cnt}, 32'd0);
        chk("flush_wen", {31'd0, predictor_wen}, 32'd1);
        tick();
        chk("flush_one_wen", {31'd0, predictor_wen}, 32'd0);

        // Reset in the middle of operation drops the in-flight branch
        tbl[8'h80] = 2'b01;
        fetch_valid = 1'b1;
        fetch_pc = 32'h600;
        pred_q.push_back(1'b0);
        tick();
        fetch_valid = 1'b0;
        tick();
        chk("cnt_pre_rst", {29'd0, inflight_cnt}, 32'd1);
        cpu_rstn = 1'b0;
        #2;
        chk("midrst_cnt", {29'd0, inflight_cnt}, 32'd0);
        chk("midrst_err", {31'd0, resolve_err}, 32'd0);
        chk("midrst_ready", {31'd0, fetch_ready}, 32'd1);
        tick();
        cpu_rstn = 1'b1;
        tick();
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        tick();
        resolve_valid = 1'b0;
        chk("midrst_discarded", {31'd0, resolve_err}, 32'd1);
        tick();
        tick();

        chk("pred_q_empty", 32'(pred_q.size()), 32'd0);
        chk("upd_q_empty", 32'(upd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
